// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Write-back arbiter and buffer for the register file write port.
// Two producers (LSU and ALU) push register writes into a small in-order
// FIFO. The head is issued to the register file through a registered port,
// at most one write per cycle. Writes still waiting in the FIFO or sitting
// in the output register are forwarded to the decode stage through two
// combinational bypass ports.
//
// Ports
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_lsu_valid / o_lsu_ready    LSU request handshake
//   i_lsu_waddr, i_lsu_wdata     LSU destination register and data
//   i_alu_valid / o_alu_ready    ALU request handshake
//   i_alu_waddr, i_alu_wdata     ALU destination register and data
//   o_rf_we, o_rf_waddr,         registered register-file write port
//   o_rf_wdata
//   i_byp_raddr1/2               decode-stage read addresses
//   o_byp_hit1/2, o_byp_data1/2  forwarding result per read port
//   o_count, o_full, o_empty     FIFO occupancy
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_lsu_valid,
  output logic                     o_lsu_ready,
  input  logic [4:0]               i_lsu_waddr,
  input  logic [31:0]              i_lsu_wdata,
  input  logic                     i_alu_valid,
  output logic                     o_alu_ready,
  input  logic [4:0]               i_alu_waddr,
  input  logic [31:0]              i_alu_wdata,
  output logic                     o_rf_we,
  output logic [4:0]               o_rf_waddr,
  output logic [31:0]              o_rf_wdata,
  input  logic [4:0]               i_byp_raddr1,
  input  logic [4:0]               i_byp_raddr2,
  output logic                     o_byp_hit1,
  output logic                     o_byp_hit2,
  output logic [31:0]              o_byp_data1,
  output logic [31:0]              o_byp_data2,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    r_mem_addr [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_rf_we;
  logic [4:0]    r_rf_waddr;
  logic [31:0]   r_rf_wdata;

  logic [CW-1:0] w_free;
  logic          w_lsu_push;
  logic          w_alu_push;
  logic          w_pop;
  logic [PW-1:0] w_alu_slot;
  logic          w_hit1;
  logic          w_hit2;
  logic [31:0]   w_data1;
  logic [31:0]   w_data2;

  // Free space comes from the registered count only, so an entry popped this
  // cycle cannot be reused by a push in the same cycle. The ALU needs a
  // second slot whenever the LSU is also asking, which makes alu_ready
  // depend on lsu_valid.
  assign w_free      = CW'(DEPTH) - r_count;
  assign o_lsu_ready = (w_free >= CW'(1));
  assign o_alu_ready = (w_free >= (CW'(1) + CW'(i_lsu_valid)));

  // Writes to r0 complete the handshake but never occupy a slot.
  assign w_lsu_push = i_lsu_valid && o_lsu_ready && (i_lsu_waddr != 5'd0);
  assign w_alu_push = i_alu_valid && o_alu_ready && (i_alu_waddr != 5'd0);
  assign w_pop      = (r_count != '0);

  // The LSU entry is older, so when both push the ALU lands one slot later.
  assign w_alu_slot = r_tail + PW'(w_lsu_push);

  // Queue storage carries no reset; validity is defined by head and count.
  always_ff @(posedge i_clk) begin
    if (w_lsu_push) begin
      r_mem_addr[r_tail] <= i_lsu_waddr;
      r_mem_data[r_tail] <= i_lsu_wdata;
    end
    if (w_alu_push) begin
      r_mem_addr[w_alu_slot] <= i_alu_waddr;
      r_mem_data[w_alu_slot] <= i_alu_wdata;
    end
  end

  // Pointer, occupancy and output register. The head is issued on every
  // edge where the queue was non-empty; the address/data hold otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_tail  <= r_tail + PW'(w_lsu_push) + PW'(w_alu_push);
      r_count <= r_count + CW'(w_lsu_push) + CW'(w_alu_push) - CW'(w_pop);
      r_rf_we <= w_pop;
      if (w_pop) begin
        r_rf_waddr <= r_mem_addr[r_head];
        r_rf_wdata <= r_mem_data[r_head];
        r_head     <= r_head + PW'(1);
      end
    end
  end

  // Bypass search walks the queue from oldest to youngest so the youngest
  // match overwrites earlier ones. The output register is only consulted
  // when nothing in the queue matches, and r0 is forced to miss.
  always_comb begin
    logic [PW-1:0] w_idx;
    w_hit1  = 1'b0;
    w_hit2  = 1'b0;
    w_data1 = '0;
    w_data2 = '0;
    w_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (CW'(i) < r_count) begin
        if (r_mem_addr[w_idx] == i_byp_raddr1) begin
          w_hit1  = 1'b1;
          w_data1 = r_mem_data[w_idx];
        end
        if (r_mem_addr[w_idx] == i_byp_raddr2) begin
          w_hit2  = 1'b1;
          w_data2 = r_mem_data[w_idx];
        end
      end
    end
    if (!w_hit1 && r_rf_we && (r_rf_waddr == i_byp_raddr1)) begin
      w_hit1  = 1'b1;
      w_data1 = r_rf_wdata;
    end
    if (!w_hit2 && r_rf_we && (r_rf_waddr == i_byp_raddr2)) begin
      w_hit2  = 1'b1;
      w_data2 = r_rf_wdata;
    end
    if (i_byp_raddr1 == 5'd0) begin
      w_hit1  = 1'b0;
      w_data1 = '0;
    end
    if (i_byp_raddr2 == 5'd0) begin
      w_hit2  = 1'b0;
      w_data2 = '0;
    end
  end

  assign o_byp_hit1  = w_hit1;
  assign o_byp_hit2  = w_hit2;
  assign o_byp_data1 = w_data1;
  assign o_byp_data2 = w_data2;

  assign o_rf_we    = r_rf_we;
  assign o_rf_waddr = r_rf_waddr;
  assign o_rf_wdata = r_rf_wdata;

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//
// Self-checking bench for wb_arbiter. A queue-based model tracks pending
// writes and the output register; a negedge process compares every DUT
// output against it each cycle. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          lsuValid;
  logic          lsuReady;
  logic [4:0]    lsuWaddr;
  logic [31:0]   lsuWdata;
  logic          aluValid;
  logic          aluReady;
  logic [4:0]    aluWaddr;
  logic [31:0]   aluWdata;
  logic          rfWe;
  logic [4:0]    rfWaddr;
  logic [31:0]   rfWdata;
  logic [4:0]    raddr1;
  logic [4:0]    raddr2;
  logic          hit1;
  logic          hit2;
  logic [31:0]   data1;
  logic [31:0]   data2;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  int nChecks = 0;
  int nFails  = 0;

  // Model state: pending writes {addr, data}, oldest at index 0.
  logic [36:0] mq[$];
  logic        mWe;
  logic [4:0]  mAddr;
  logic [31:0] mData;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_lsu_valid  (lsuValid),
    .o_lsu_ready  (lsuReady),
    .i_lsu_waddr  (lsuWaddr),
    .i_lsu_wdata  (lsuWdata),
    .i_alu_valid  (aluValid),
    .o_alu_ready  (aluReady),
    .i_alu_waddr  (aluWaddr),
    .i_alu_wdata  (aluWdata),
    .o_rf_we      (rfWe),
    .o_rf_waddr   (rfWaddr),
    .o_rf_wdata   (rfWdata),
    .i_byp_raddr1 (raddr1),
    .i_byp_raddr2 (raddr2),
    .o_byp_hit1   (hit1),
    .o_byp_hit2   (hit2),
    .o_byp_data1  (data1),
    .o_byp_data2  (data2),
    .o_count      (count),
    .o_full       (full),
    .o_empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mWe   = 1'b0;
    mAddr = '0;
    mData = '0;
  endtask

  // One clock edge of the model: readiness from pre-edge occupancy, pop the
  // oldest pending write into the output register, then append accepted
  // non-r0 requests (LSU before ALU).
  task automatic modelStep();
    int  freeSlots;
    bit  lAcc;
    bit  aAcc;
    freeSlots = DEPTH - mq.size();
    lAcc = lsuValid && (freeSlots >= 1);
    aAcc = aluValid && (freeSlots >= 1 + int'(lsuValid));
    if (mq.size() != 0) begin
      mWe = 1'b1;
      {mAddr, mData} = mq.pop_front();
    end else begin
      mWe = 1'b0;
    end
    if (lAcc && lsuWaddr != 5'd0) mq.push_back({lsuWaddr, lsuWdata});
    if (aAcc && aluWaddr != 5'd0) mq.push_back({aluWaddr, aluWdata});
  endtask

  function automatic void modelBypass(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i][36:32] == a) begin
          h = 1'b1;
          d = mq[i][31:0];
          break;
        end
      end
      if (!h && mWe && mAddr == a) begin
        h = 1'b1;
        d = mData;
      end
    end
  endfunction

  // Compare process: every cycle, away from the active edge.
  logic        expHit1;
  logic        expHit2;
  logic [31:0] expData1;
  logic [31:0] expData2;
  int          cmpFree;

  always @(negedge clk) begin
    cmpFree = DEPTH - mq.size();
    checkOutput("lsu_ready", 32'(lsuReady), 32'(cmpFree >= 1));
    checkOutput("alu_ready", 32'(aluReady), 32'(cmpFree >= 1 + int'(lsuValid)));
    checkOutput("count", 32'(count), 32'(mq.size()));
    checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
    checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
    checkOutput("rf_we", 32'(rfWe), 32'(mWe));
    checkOutput("rf_waddr", 32'(rfWaddr), 32'(mAddr));
    checkOutput("rf_wdata", rfWdata, mData);
    modelBypass(raddr1, expHit1, expData1);
    modelBypass(raddr2, expHit2, expData2);
    checkOutput("byp_hit1", 32'(hit1), 32'(expHit1));
    checkOutput("byp_data1", data1, expData1);
    checkOutput("byp_hit2", 32'(hit2), 32'(expHit2));
    checkOutput("byp_data2", data2, expData2);
  end

  // Drive one cycle's inputs shortly after an edge and let them settle.
  task automatic applyStimulus(input logic lv, input logic [4:0] la, input logic [31:0] ld,
                               input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic [4:0] r1, input logic [4:0] r2);
    lsuValid = lv;
    lsuWaddr = la;
    lsuWdata = ld;
    aluValid = av;
    aluWaddr = aa;
    aluWdata = ad;
    raddr1   = r1;
    raddr2   = r2;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, raddr1, raddr2);
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    modelReset();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_full", 32'(full), 32'd0);
    checkOutput("reset_rf_we", 32'(rfWe), 32'd0);
    checkOutput("reset_rf_waddr", 32'(rfWaddr), 32'd0);
    checkOutput("reset_hit1", 32'(hit1), 32'd0);

    // Single ALU write to r5
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    advance();
    checkOutput("single_queued_hit", 32'(hit1), 32'd1);
    checkOutput("single_queued_data", data1, 32'hDEADBEEF);
    checkOutput("single_no_we_yet", 32'(rfWe), 32'd0);
    idle(1);
    checkOutput("single_we", 32'(rfWe), 32'd1);
    checkOutput("single_waddr", 32'(rfWaddr), 32'd5);
    checkOutput("single_wdata", rfWdata, 32'hDEADBEEF);
    checkOutput("single_outreg_hit", 32'(hit1), 32'd1);
    idle(1);
    checkOutput("single_we_off", 32'(rfWe), 32'd0);
    checkOutput("single_hit_off", 32'(hit1), 32'd0);

    // Dual push to r3: LSU older than ALU
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd5);
    advance();
    checkOutput("dual_count", 32'(count), 32'd2);
    checkOutput("dual_byp_young", data1, 32'h22);
    idle(1);
    checkOutput("dual_first_issue", rfWdata, 32'h11);
    checkOutput("dual_byp_queue", data1, 32'h22);
    idle(1);
    checkOutput("dual_second_issue", rfWdata, 32'h22);
    checkOutput("dual_byp_outreg", data1, 32'h22);
    idle(2);

    // Fill / backpressure with addresses 1..8
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 5'(2 * k + 1), 32'(32'h1000 + 2 * k + 1),
                    1'b1, 5'(2 * k + 2), 32'(32'h1000 + 2 * k + 2), 5'd8, 5'd1);
      if (k >= 2) begin
        checkOutput("fill_alu_blocked", 32'(aluReady), 32'd0);
        checkOutput("fill_lsu_open", 32'(lsuReady), 32'd1);
      end
      advance();
      if (k == 1) checkOutput("fill_first_issue", 32'(rfWaddr), 32'd1);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1009, 5'd9, 5'd7);
    checkOutput("fill_count3", 32'(count), 32'd3);
    checkOutput("fill_alu_alone", 32'(aluReady), 32'd1);
    advance();
    idle(6);

    // r0 drop
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
    checkOutput("r0_ready", 32'(aluReady), 32'd1);
    advance();
    checkOutput("r0_count", 32'(count), 32'd0);
    checkOutput("r0_no_we", 32'(rfWe), 32'd0);
    checkOutput("r0_no_hit", 32'(hit1), 32'd0);
    idle(1);

    // Reset with three entries pending
    applyStimulus(1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB, 5'd11, 5'd12);
    advance();
    applyStimulus(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD, 5'd11, 5'd12);
    advance();
    checkOutput("prereset_count", 32'(count), 32'd3);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd11, 5'd12);
    #1;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("midreset_rf_we", 32'(rfWe), 32'd0);
    checkOutput("midreset_empty", 32'(empty), 32'd1);
    checkOutput("midreset_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checkOutput("postreset_no_we", 32'(rfWe), 32'd0);
    end

    // Bypass priority on r7
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0, 5'd7, 5'd3);
    advance();
    applyStimulus(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd7, 5'd3);
    advance();
    checkOutput("prio_outreg_addr", 32'(rfWaddr), 32'd7);
    checkOutput("prio_outreg_data", rfWdata, 32'h0);
    checkOutput("prio_data", data1, 32'h2);
    checkOutput("prio_miss_r3", 32'(hit2), 32'd0);
    idle(1);
    checkOutput("prio_mid_data", data1, 32'h2);
    idle(1);
    checkOutput("prio_outreg_hit", 32'(hit1), 32'd1);
    checkOutput("prio_outreg_follow", data1, 32'h2);
    idle(1);
    checkOutput("prio_final_miss", 32'(hit1), 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and buffer that drives the single write port of the register file. It accepts register write requests from two producers, the ALU and the load/store unit. It queues them in a small in-order FIFO and issues at most one register-file write per cycle. It also supplies forwarding data for writes that are still pending, so the decode stage never reads a stale register value.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- lsu_valid  in  1  LSU write request.
- lsu_ready  out  1  LSU request accepted this cycle when lsu_valid & lsu_ready.
- lsu_waddr  in  5  LSU destination register.
- lsu_wdata  in  32  LSU write data.
- alu_valid / alu_ready / alu_waddr / alu_wdata: same widths and semantics as the LSU ports, for the ALU.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  32  register-file write data (registered).
- byp_raddr1, byp_raddr2  in  5  decode-stage read addresses.
- byp_hit1, byp_hit2  out  1  pending write to that address exists.
- byp_data1, byp_data2  out  32  youngest pending data for that address; 0 when no hit.
- count  out  $clog2(DEPTH)+1  occupied entries.
- full, empty  out  1  count==DEPTH, count==0.

## Operation
- Each queue entry holds {waddr[4:0], wdata[31:0]}. Head/tail pointers wrap modulo DEPTH. Occupancy is tracked by count.
- free = DEPTH − count. This uses the registered count, so a pop in the same cycle does not free space for a push.
- lsu_ready = (free ≥ 1).
- alu_ready = (free ≥ 1 + lsu_valid). alu_ready depends combinationally on lsu_valid; this is the only valid-to-ready path.
- Simultaneous accepts: the LSU entry is enqueued first (older), then the ALU entry. The tail advances by 2.
- Requests with waddr == 0 are accepted normally (ready obeys the rules above) but are not enqueued. Count and tail are unchanged by them.
- Issue: on every clock edge where count ≠ 0, the head is popped into rf_we=1, rf_waddr, rf_wdata. When count == 0, rf_we=0 and rf_waddr/rf_wdata hold their last values.
- Count update: count_next = count + pushes − pop. Pushes are 0–2, pop is 0–1.
- Bypass for each read port, in priority order:
  - The youngest matching queue entry (the one nearest the tail) wins.
  - Otherwise, the output register wins if rf_we=1 and rf_waddr matches. This covers the write the register file has not yet committed.
  - Otherwise hit=0 and data=0.
  - Address 0 never hits.
- Incoming same-cycle requests are not visible to bypass.
- Bypass outputs are purely combinational from state and byp_raddr.
- No stall input: the register file always accepts a write.

## Timing
- Reset (async assert, released synchronously by the system): count=0, head=tail=0, rf_we=0, rf_waddr=0, rf_wdata=0, empty=1, full=0.
  - byp_hit*=0 and byp_data*=0 for any address.
  - Queue contents are don't-care.
- Reset mid-operation discards all pending entries; no write is issued for them.
- Latency for a request accepted at edge E into an empty queue:
  - Entry is visible to bypass after E.
  - rf_we=1 after edge E+1.
  - Register file is updated at edge E+2.
  - Bypass hit persists through the cycle before E+2.
- Throughput: one write per cycle sustained. With both sources pushing every cycle the queue fills, and alu_ready drops first.
- Full: both ready=0. With count == DEPTH−1: lsu_ready=1, and alu_ready=1 only when lsu_valid=0.
- Pop and push in the same cycle at full: the push is rejected (ready already 0). Count becomes DEPTH−1.

## Test plan
- Single ALU write: alu_valid, waddr=5, wdata=0xDEADBEEF for one cycle from reset.
  - Required: rf_we=1 with waddr=5 and wdata=0xDEADBEEF exactly one cycle after acceptance, then rf_we=0.
  - Required: byp_hit1 for raddr=5 for 2 cycles.
- Dual push ordering: LSU (r3, 0x11) and ALU (r3, 0x22) in the same cycle.
  - Required: writes issue 0x11 then 0x22 on consecutive cycles.
  - Required: bypass of r3 returns 0x22 until the queue drains, then 0x22 from the output register.
- Fill/backpressure: DEPTH=4, both sources valid for 4 cycles with distinct addresses 1..8.
  - Required: exactly the ready handshakes allowed by the free rules; count never exceeds 4.
  - Required: every accepted write appears once, in order, with no loss or duplication.
- r0 drop: alu_valid with waddr=0, wdata=0xFFFF.
  - Required: alu_ready=1, count unchanged, no rf_we, byp_hit for raddr 0 stays 0.
- Reset mid-queue: 3 entries pending, assert rst asynchronously between edges.
  - Required: rf_we=0, empty=1, count=0 immediately; no writes issued after release.
- Bypass priority: queue holds r7=0x1 (older) and r7=0x2, while the output register holds r7=0x0.
  - Required: byp_data=0x2. After both entries drain, the data follows the output register, then hit=0.
